// File: rtl/rz_decode.sv
// Return-to-zero (WS2812-style) single-wire receiver: recovers bits from
// high-pulse widths and emits 24-bit GRB words, frame-end strobes and errors.
module rz_decode #(
    parameter int unsigned BIT_THRESH = 45,
    parameter int unsigned HIGH_MIN   = 8,
    parameter int unsigned HIGH_MAX   = 90,
    parameter int unsigned RESET_CYC  = 3712
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rz_in,
    output logic [23:0] word_data,
    output logic        word_valid,
    output logic [7:0]  led_index,
    output logic        frame_done,
    output logic [7:0]  frame_len,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned HW = 8;
    localparam int unsigned LW = 16;
    localparam int unsigned BW = 5;
    localparam int unsigned DW = 24;

    localparam logic [1:0] ERR_LONG    = 2'b01;
    localparam logic [1:0] ERR_GLITCH  = 2'b10;
    localparam logic [1:0] ERR_PARTIAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_HIGH,
        S_LOW
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [HW-1:0]   high_cnt_q, high_cnt_d;
    logic [LW-1:0]   low_cnt_q, low_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      word_cnt_q, word_cnt_d;
    logic [DW-2:0]   shift_q, shift_d;
    logic [DW-1:0]   word_data_q, word_data_d;
    logic            word_valid_q, word_valid_d;
    logic [7:0]      led_index_q, led_index_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_len_q, frame_len_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            rise, fall, bit_val;
    logic [HW-1:0]   high_inc;
    logic [LW-1:0]   low_inc;
    logic [7:0]      word_inc;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign bit_val  = (high_cnt_q >= HW'(BIT_THRESH));
    assign high_inc = (&high_cnt_q) ? high_cnt_q : high_cnt_q + HW'(1);
    assign low_inc  = (&low_cnt_q)  ? low_cnt_q  : low_cnt_q + LW'(1);
    assign word_inc = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 8'(1);

    // Next-state, counters and registered-output values
    always_comb begin
        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        led_index_d  = led_index_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            S_IDLE: begin
                low_cnt_d = s2_q ? LW'(0) : low_inc;
                if (low_cnt_q >= LW'(RESET_CYC)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (rise) begin
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                // Too-long check wins over a coincident fall
                if (high_cnt_q >= HW'(HIGH_MAX)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LONG;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    low_cnt_d  = '0;
                    state_d    = S_IDLE;
                end else if (fall) begin
                    if (high_cnt_q < HW'(HIGH_MIN)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_GLITCH;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        low_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        shift_d   = {shift_q[DW-3:0], bit_val};
                        low_cnt_d = LW'(1);
                        state_d   = S_LOW;
                        if (bit_cnt_q == BW'(DW - 1)) begin
                            word_data_d  = {shift_q, bit_val};
                            word_valid_d = 1'b1;
                            led_index_d  = word_cnt_q;
                            word_cnt_d   = word_inc;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end else if (s2_q) begin
                    high_cnt_d = high_inc;
                end
            end
            S_LOW: begin
                if (low_cnt_q >= LW'(RESET_CYC)) begin
                    frame_done_d = 1'b1;
                    frame_len_d  = word_cnt_q;
                    if (bit_cnt_q != '0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PARTIAL;
                    end
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = S_READY;
                end else if (rise) begin
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end else if (!s2_q) begin
                    low_cnt_d = low_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            led_index_q  <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= rz_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            led_index_q  <= led_index_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign led_index  = led_index_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_rz_decode.sv
// Directed bench for rz_decode: pin-level pulse stimulus with a queue of
// expected output events checked by an independent monitor.
module tb_rz_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rz_in = 1'b0;
    logic [23:0] word_data;
    logic        word_valid;
    logic [7:0]  led_index;
    logic        frame_done;
    logic [7:0]  frame_len;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        wv;
        logic [23:0] wd;
        logic [7:0]  li;
        logic        fd;
        logic [7:0]  fl;
        logic        er;
        logic [1:0]  ec;
    } ev_t;

    ev_t exp_q[$];

    rz_decode dut (
        .clk        (clk),
        .rst        (rst),
        .rz_in      (rz_in),
        .word_data  (word_data),
        .word_valid (word_valid),
        .led_index  (led_index),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Fields that are not qualified by their strobe are ignored
    function automatic ev_t mask_ev(input ev_t e);
        ev_t m;
        m = e;
        if (!m.wv) begin m.wd = '0; m.li = '0; end
        if (!m.fd) m.fl = '0;
        if (!m.er) m.ec = '0;
        return m;
    endfunction

    task automatic exp_word(input logic [23:0] d, input logic [7:0] idx);
        ev_t e = '0;
        e.wv = 1'b1; e.wd = d; e.li = idx;
        exp_q.push_back(e);
    endtask

    task automatic exp_frame(input logic [7:0] len, input logic partial);
        ev_t e = '0;
        e.fd = 1'b1; e.fl = len;
        if (partial) begin e.er = 1'b1; e.ec = 2'b11; end
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code);
        ev_t e = '0;
        e.er = 1'b1; e.ec = code;
        exp_q.push_back(e);
    endtask

    // Monitor: any strobe pops one expected event
    always @(negedge clk) begin
        if (!rst && (word_valid || frame_done || err)) begin
            ev_t obs, exp_e;
            obs = mask_ev({word_valid, word_data, led_index, frame_done, frame_len, err, err_code});
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%h required=none", obs);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs !== exp_e) begin
                    failures++;
                    $display("FAIL event got=%h required=%h (wv,wd,li,fd,fl,er,ec)", obs, exp_e);
                end
            end
        end
    end

    // Entry and exit at a falling clock edge
    task automatic pulse(input int hi, input int lo);
        rz_in = 1'b1;
        repeat (hi) @(negedge clk);
        rz_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(59, 34);
        else   pulse(30, 63);
    endtask

    task automatic send_bits(input logic [23:0] w, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) send_bit(w[i]);
    endtask

    task automatic gap(input int n);
        rz_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        logic [46:0] all_out;
        all_out = {word_data, word_valid, led_index, frame_done, frame_len, err, err_code};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL %s got=%h required=0", name, all_out);
        end
    endtask

    initial begin
        repeat (900000) @(posedge clk);
        $display("FAIL watchdog got=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        // Single word 0xFF0000 framed by gaps
        gap(3750);
        exp_word(24'hFF0000, 8'd0);
        exp_frame(8'd1, 1'b0);
        send_bits(24'hFF0000, 23, 0);
        gap(3750);

        // Two words in one frame
        exp_word(24'h123456, 8'd0);
        exp_word(24'hABCDEF, 8'd1);
        exp_frame(8'd2, 1'b0);
        send_bits(24'h123456, 23, 0);
        send_bits(24'hABCDEF, 23, 0);
        gap(3750);

        // Boundaries: 44->0, 45->1 then low 3711, 8 valid ->0, 89 valid ->1
        exp_word(24'h5A5A5A, 8'd0);
        exp_frame(8'd1, 1'b0);
        pulse(44, 63);
        pulse(45, 3711);
        pulse(8, 63);
        pulse(89, 34);
        send_bits(24'h5A5A5A, 19, 0);
        gap(3750);

        // Over-long high mid-word, then ignored stream until a full gap
        exp_err(2'b01);
        send_bits(24'hFFFFFF, 23, 19);
        pulse(100, 34);
        send_bits(24'hFFFFFF, 23, 0);
        gap(3750);
        exp_word(24'h0F0F0F, 8'd0);
        exp_frame(8'd1, 1'b0);
        send_bits(24'h0F0F0F, 23, 0);
        gap(3750);

        // Partial word at gap, then a glitch pulse
        exp_frame(8'd0, 1'b1);
        send_bits(24'hABC000, 23, 12);
        gap(3750);
        exp_err(2'b10);
        pulse(4, 63);
        gap(3750);

        // Reset mid-word: outputs clear, resumed stream ignored until a gap
        send_bits(24'h3C3C3C, 23, 14);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_mid_word");
        rst = 1'b0;
        send_bits(24'h3C3C3C, 13, 0);
        send_bits(24'h777777, 23, 0);
        gap(3750);
        exp_word(24'hC3C3C3, 8'd0);
        exp_frame(8'd1, 1'b0);
        send_bits(24'hC3C3C3, 23, 0);
        gap(3750);

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
